// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the wait-stated byte-enabled data memory responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int BYTES = 4;
  localparam int CNT_W = 4;

  // Misaligned, or word index beyond a 2**aw-word memory.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 32'd2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_be_ram.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered read port.
module dmem_be_ram
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BYTES-1:0] we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-lane writes; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read register holds data only for the cycle after a read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end else begin
      rdata_q <= 32'h0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: req/ready handshake, WAIT_STATES extra cycles, byte-lane
// writes and address error reporting on top of dmem_be_ram.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [31:0]      a,
  input  logic [31:0]      wd,
  input  logic [BYTES-1:0] be,
  output logic [31:0]      rd,
  output logic             ready,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wd_q, wd_d;
  logic [BYTES-1:0] be_q, be_d;
  logic             ready_q;
  logic             err_q;

  logic [31:0]      cur_addr_s;
  logic             cur_we_s;
  logic [31:0]      cur_wd_s;
  logic [BYTES-1:0] cur_be_s;
  logic             go_resp_s;
  logic             err_s;
  logic [BYTES-1:0] ram_we_s;
  logic             ram_re_s;

  // Next-state, wait counter and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wd_d    = wd_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = a;
          we_d   = we;
          wd_d   = wd;
          be_d   = be;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = RESP;
            cnt_d   = {CNT_W{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no wait states RESP is entered straight from IDLE, so the live inputs are used.
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr_s = a;
      cur_we_s   = we;
      cur_wd_s   = wd;
      cur_be_s   = be;
    end else begin
      cur_addr_s = addr_q;
      cur_we_s   = we_q;
      cur_wd_s   = wd_q;
      cur_be_s   = be_q;
    end
  end

  assign go_resp_s = (state_d == RESP) && (state_q != RESP);
  assign err_s     = addr_err(cur_addr_s, AW);
  assign ram_we_s  = (go_resp_s && cur_we_s && !err_s) ? cur_be_s : {BYTES{1'b0}};
  assign ram_re_s  = go_resp_s && !cur_we_s && !err_s;

  // State, counter, latched request and output flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      wd_q    <= 32'h0;
      be_q    <= {BYTES{1'b0}};
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      ready_q <= go_resp_s;
      err_q   <= go_resp_s && err_s;
    end
  end

  dmem_be_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (ram_we_s),
    .re_i    (ram_re_s),
    .addr_i  (cur_addr_s[AW+1:2]),
    .wdata_i (cur_wd_s),
    .rdata_o (rd)
  );

  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboarded directed bench for dmem_resp with zero and three wait states.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        is_rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req3, we3;
  logic [31:0] a0, wd0, a3, wd3;
  logic [3:0]  be0, be3;
  logic [31:0] rd0, rd3;
  logic        ready0, err0, ready3, err3;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [31:0] m0 [64];
  logic [31:0] m3 [64];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_resp #(.DEPTH(64), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(rst_n), .req(req0), .we(we0), .a(a0), .wd(wd0), .be(be0),
    .rd(rd0), .ready(ready0), .err(err0)
  );

  dmem_resp #(.DEPTH(64), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(rst_n), .req(req3), .we(we3), .a(a3), .wd(wd3), .be(be3),
    .rd(rd3), .ready(ready3), .err(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 0 : 3;
  endfunction

  function automatic logic get_rdy(input int inst);
    return (inst == 0) ? ready0 : ready3;
  endfunction

  function automatic logic get_err(input int inst);
    return (inst == 0) ? err0 : err3;
  endfunction

  function automatic logic [31:0] get_rd(input int inst);
    return (inst == 0) ? rd0 : rd3;
  endfunction

  task automatic drive(input int inst, input logic r, input logic w, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] bm);
    if (inst == 0) begin
      req0 = r; we0 = w; a0 = addr; wd0 = wdata; be0 = bm;
    end else begin
      req3 = r; we3 = w; a3 = addr; wd3 = wdata; be3 = bm;
    end
  endtask

  // Reference model: update memory image and queue the expected response.
  task automatic push_exp(input int inst, input logic w, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] bm);
    exp_t e;
    logic bad;
    int   idx;
    bad     = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd64);
    idx     = int'(addr[7:2]);
    e.err   = bad;
    e.is_rd = !w;
    e.rd    = 32'h0;
    if (!bad) begin
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (bm[i]) begin
            if (inst == 0) m0[idx][8*i +: 8] = wdata[8*i +: 8];
            else           m3[idx][8*i +: 8] = wdata[8*i +: 8];
          end
        end
      end else begin
        e.rd = (inst == 0) ? m0[idx] : m3[idx];
      end
    end
    sb.push_back(e);
  endtask

  task automatic wait_ready(input int inst, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!get_rdy(inst) && lat < 40);
    if (!get_rdy(inst)) check("ready_timeout", {31'd0, get_rdy(inst)}, 32'd1);
  endtask

  task automatic compare_pop(input int inst);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("err", {31'd0, get_err(inst)}, {31'd0, e.err});
      if (e.is_rd) check("rd", get_rd(inst), e.rd);
    end
  endtask

  task automatic xact(input int inst, input logic w, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] bm);
    int lat;
    push_exp(inst, w, addr, wdata, bm);
    @(negedge clk);
    drive(inst, 1'b1, w, addr, wdata, bm);
    @(posedge clk);
    #1 drive(inst, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0);
    wait_ready(inst, lat);
    check("latency", 32'(lat), 32'(ws_of(inst) + 1));
    compare_pop(inst);
    @(negedge clk);
    check("ready_pulse", {31'd0, get_rdy(inst)}, 32'd0);
    check("rd_idle", get_rd(inst), 32'h0);
  endtask

  // req held high; the next request is presented during each RESP cycle.
  task automatic b2b(input int inst, input int n);
    int          lat, prev;
    logic [31:0] d;
    logic        w;
    prev = 0;
    d    = 32'hC0DE_0000 + 32'(inst);
    push_exp(inst, 1'b1, 32'h40, d, 4'hF);
    @(negedge clk);
    drive(inst, 1'b1, 1'b1, 32'h40, d, 4'hF);
    for (int j = 0; j < n; j++) begin
      wait_ready(inst, lat);
      if (j > 0) check("b2b_period", 32'(cyc - prev), 32'(ws_of(inst) + 2));
      prev = cyc;
      compare_pop(inst);
      if (j < n - 1) begin
        w = ((j + 1) % 2) == 0;
        if (w) d = d + 32'h0101_0101;
        push_exp(inst, w, 32'h40, d, 4'hF);
        drive(inst, 1'b1, w, 32'h40, d, 4'hF);
      end else begin
        drive(inst, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    check("rst_ready0", {31'd0, ready0}, 32'd0);
    check("rst_err0",   {31'd0, err0},   32'd0);
    check("rst_rd0",    rd0,             32'h0);
    check("rst_ready3", {31'd0, ready3}, 32'd0);
    check("rst_err3",   {31'd0, err3},   32'd0);
    check("rst_rd3",    rd3,             32'h0);
    rst_n = 1'b1;

    xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0);
    xact(0, 1'b0, 32'h100, 32'h0, 4'hF);

    xact(3, 1'b1, 32'h20, 32'hAABB_CCDD, 4'hF);
    xact(3, 1'b1, 32'h20, 32'h1122_3344, 4'b0101);
    xact(3, 1'b0, 32'h20, 32'h0, 4'h0);
    check("model_merge", m3[8], 32'hAA22_CC44);

    xact(3, 1'b0, 32'h22, 32'h0, 4'hF);
    xact(3, 1'b0, 32'h100, 32'h0, 4'hF);
    xact(3, 1'b1, 32'h21, 32'hFFFF_FFFF, 4'hF);
    xact(3, 1'b1, 32'h104, 32'hFFFF_FFFF, 4'hF);
    xact(3, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0);
    xact(3, 1'b0, 32'h20, 32'h0, 4'h0);

    // Abort a write while it is counting wait states.
    xact(3, 1'b1, 32'h30, 32'h1234_5678, 4'hF);
    @(negedge clk);
    drive(3, 1'b1, 1'b1, 32'h30, 32'h5555_5555, 4'hF);
    @(posedge clk);
    #1 drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    check("pre_abort_wait", {30'd0, u3.state_q}, {30'd0, WAIT});
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready3}, 32'd0);
    check("abort_err",   {31'd0, err3},   32'd0);
    check("abort_rd",    rd3,             32'h0);
    check("abort_state", {30'd0, u3.state_q}, {30'd0, IDLE});
    check("abort_cnt",   {28'd0, u3.cnt_q},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready3) seen++;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    xact(3, 1'b0, 32'h30, 32'h0, 4'h0);

    b2b(0, 6);
    b2b(3, 6);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
